// File: rtl/instruction_decode_stage_pkg.sv
// Shared definitions for the instruction decode stage: default field widths,
// field-position helper and the decoded-instruction type held by both buffer entries.
package instruction_decode_stage_pkg;

  localparam int unsigned DefInstrWidth  = 32;
  localparam int unsigned DefOpcodeWidth = 4;
  localparam int unsigned DefImmWidth    = 8;
  localparam int unsigned DefRegSelWidth = 2;

  // Storage ceilings for the decoded type; narrower parameterisations zero-extend into it.
  localparam int unsigned MaxOpcodeWidth = 8;
  localparam int unsigned MaxImmWidth    = 16;
  localparam int unsigned MaxRegSelWidth = 8;

  typedef enum logic [2:0] {
    FieldOpcode,
    FieldType1,
    FieldOperand1,
    FieldType2,
    FieldOperand2,
    FieldOutSel
  } field_e;

  typedef struct packed {
    logic [MaxOpcodeWidth-1:0] opcode;
    logic                      type_1;
    logic [MaxRegSelWidth-1:0] sel_1;
    logic [MaxImmWidth-1:0]    imm_1;
    logic                      type_2;
    logic [MaxRegSelWidth-1:0] sel_2;
    logic [MaxImmWidth-1:0]    imm_2;
    logic [MaxRegSelWidth-1:0] out_sel;
    logic                      illegal;
  } decoded_instr_t;

  // LSB position of a field; fields are packed from the MSB downwards and the
  // out-select LSB doubles as the width of the reserved low bits.
  function automatic int unsigned field_lsb(field_e field, int unsigned instr_w,
                                            int unsigned opcode_w, int unsigned imm_w,
                                            int unsigned sel_w);
    int unsigned opc_lsb;
    int unsigned t1_lsb;
    int unsigned op1_lsb;
    int unsigned t2_lsb;
    int unsigned op2_lsb;
    opc_lsb = instr_w - opcode_w;
    t1_lsb  = opc_lsb - 1;
    op1_lsb = t1_lsb - imm_w;
    t2_lsb  = op1_lsb - 1;
    op2_lsb = t2_lsb - imm_w;
    case (field)
      FieldOpcode:   return opc_lsb;
      FieldType1:    return t1_lsb;
      FieldOperand1: return op1_lsb;
      FieldType2:    return t2_lsb;
      FieldOperand2: return op2_lsb;
      FieldOutSel:   return op2_lsb - sel_w;
      default:       return 0;
    endcase
  endfunction

endpackage

// File: rtl/instruction_decode_stage_extract.sv
// Combinational field extraction and legality check for one raw instruction word.
module instruction_field_extract
  import instruction_decode_stage_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH   = DefInstrWidth,
  parameter int unsigned OPCODE_WIDTH  = DefOpcodeWidth,
  parameter int unsigned IMM_WIDTH     = DefImmWidth,
  parameter int unsigned REG_SEL_WIDTH = DefRegSelWidth,
  parameter logic [2**OPCODE_WIDTH-1:0] LEGAL_OPCODE_MASK = '1
) (
  input  logic [INSTR_WIDTH-1:0] instr_i,
  output decoded_instr_t         dec_o
);

  localparam int unsigned OpcLsb =
      field_lsb(FieldOpcode, INSTR_WIDTH, OPCODE_WIDTH, IMM_WIDTH, REG_SEL_WIDTH);
  localparam int unsigned Type1Lsb =
      field_lsb(FieldType1, INSTR_WIDTH, OPCODE_WIDTH, IMM_WIDTH, REG_SEL_WIDTH);
  localparam int unsigned Op1Lsb =
      field_lsb(FieldOperand1, INSTR_WIDTH, OPCODE_WIDTH, IMM_WIDTH, REG_SEL_WIDTH);
  localparam int unsigned Type2Lsb =
      field_lsb(FieldType2, INSTR_WIDTH, OPCODE_WIDTH, IMM_WIDTH, REG_SEL_WIDTH);
  localparam int unsigned Op2Lsb =
      field_lsb(FieldOperand2, INSTR_WIDTH, OPCODE_WIDTH, IMM_WIDTH, REG_SEL_WIDTH);
  localparam int unsigned OutSelLsb =
      field_lsb(FieldOutSel, INSTR_WIDTH, OPCODE_WIDTH, IMM_WIDTH, REG_SEL_WIDTH);

  // Reserved bits are everything below the out-select field; an empty field gives a zero mask.
  localparam logic [INSTR_WIDTH-1:0] ResMask =
      (INSTR_WIDTH'(1) << OutSelLsb) - INSTR_WIDTH'(1);

  logic [OPCODE_WIDTH-1:0]  opcode;
  logic [IMM_WIDTH-1:0]     operand_1;
  logic [IMM_WIDTH-1:0]     operand_2;
  logic [REG_SEL_WIDTH-1:0] out_sel;

  assign opcode    = OPCODE_WIDTH'(instr_i >> OpcLsb);
  assign operand_1 = IMM_WIDTH'(instr_i >> Op1Lsb);
  assign operand_2 = IMM_WIDTH'(instr_i >> Op2Lsb);
  assign out_sel   = REG_SEL_WIDTH'(instr_i >> OutSelLsb);

  // Pack the decoded fields; selectors and immediates are both driven whatever the type bits say.
  always_comb begin
    dec_o         = '0;
    dec_o.opcode  = MaxOpcodeWidth'(opcode);
    dec_o.type_1  = instr_i[Type1Lsb];
    dec_o.sel_1   = MaxRegSelWidth'(operand_1[IMM_WIDTH-1 -: REG_SEL_WIDTH]);
    dec_o.imm_1   = MaxImmWidth'(operand_1);
    dec_o.type_2  = instr_i[Type2Lsb];
    dec_o.sel_2   = MaxRegSelWidth'(operand_2[IMM_WIDTH-1 -: REG_SEL_WIDTH]);
    dec_o.imm_2   = MaxImmWidth'(operand_2);
    dec_o.out_sel = MaxRegSelWidth'(out_sel);
    dec_o.illegal = ~LEGAL_OPCODE_MASK[opcode] | (|(instr_i & ResMask));
  end

endmodule

// File: rtl/instruction_decode_stage.sv
// Instruction decode stage: decodes at the input and holds results in a two-entry
// skid buffer (output register plus skid register) with a registered in_ready.
module instruction_decode_stage
  import instruction_decode_stage_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH   = DefInstrWidth,
  parameter int unsigned OPCODE_WIDTH  = DefOpcodeWidth,
  parameter int unsigned IMM_WIDTH     = DefImmWidth,
  parameter int unsigned REG_SEL_WIDTH = DefRegSelWidth,
  parameter logic [2**OPCODE_WIDTH-1:0] LEGAL_OPCODE_MASK = '1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INSTR_WIDTH-1:0]   in_instruction,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPCODE_WIDTH-1:0]  opcode,
  output logic                     input_type_1,
  output logic                     input_type_2,
  output logic [REG_SEL_WIDTH-1:0] input_register_selector_1,
  output logic [REG_SEL_WIDTH-1:0] input_register_selector_2,
  output logic [IMM_WIDTH-1:0]     input_immediate_1,
  output logic [IMM_WIDTH-1:0]     input_immediate_2,
  output logic [REG_SEL_WIDTH-1:0] output_register_selector,
  output logic                     illegal
);

  if (OPCODE_WIDTH + 2 * (1 + IMM_WIDTH) + REG_SEL_WIDTH > INSTR_WIDTH) begin : gen_width_err
    $error("instruction fields do not fit in INSTR_WIDTH");
  end
  if (REG_SEL_WIDTH > IMM_WIDTH) begin : gen_sel_err
    $error("REG_SEL_WIDTH must not exceed IMM_WIDTH");
  end
  if (OPCODE_WIDTH > MaxOpcodeWidth || IMM_WIDTH > MaxImmWidth ||
      REG_SEL_WIDTH > MaxRegSelWidth) begin : gen_max_err
    $error("field width exceeds decoded_instr_t storage");
  end

  decoded_instr_t dec_in;
  decoded_instr_t out_q, out_d, skid_q, skid_d;
  logic           out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic           accept, drain;

  instruction_field_extract #(
    .INSTR_WIDTH      (INSTR_WIDTH),
    .OPCODE_WIDTH     (OPCODE_WIDTH),
    .IMM_WIDTH        (IMM_WIDTH),
    .REG_SEL_WIDTH    (REG_SEL_WIDTH),
    .LEGAL_OPCODE_MASK(LEGAL_OPCODE_MASK)
  ) u_extract (
    .instr_i(in_instruction),
    .dec_o  (dec_in)
  );

  // in_ready comes straight from the skid flag so out_ready never reaches it.
  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & ~skid_valid_q;
  assign drain    = out_valid_q & out_ready;

  // Next-state for both entries; flush overrides every transfer.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || drain) begin
      // Output slot frees up: the older skid word goes first, otherwise the new word bypasses.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec_in;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec_in;
      skid_valid_d = 1'b1;
    end
  end

  // Buffer state; reset zeroes data too so the decoded outputs read zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid                 = out_valid_q;
  assign opcode                    = out_q.opcode[OPCODE_WIDTH-1:0];
  assign input_type_1              = out_q.type_1;
  assign input_type_2              = out_q.type_2;
  assign input_register_selector_1 = out_q.sel_1[REG_SEL_WIDTH-1:0];
  assign input_register_selector_2 = out_q.sel_2[REG_SEL_WIDTH-1:0];
  assign input_immediate_1         = out_q.imm_1[IMM_WIDTH-1:0];
  assign input_immediate_2         = out_q.imm_2[IMM_WIDTH-1:0];
  assign output_register_selector  = out_q.out_sel[REG_SEL_WIDTH-1:0];
  assign illegal                   = out_q.illegal;

  // Zero-extension headroom in the stored type is never read.
  logic unused_out_bits;
  assign unused_out_bits = ^out_q;

endmodule

// File: tb/tb_instruction_decode_stage.sv
module tb_instruction_decode_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush, out_ready;
  logic [31:0] in_instruction;
  logic        in_ready, out_valid, input_type_1, input_type_2, illegal;
  logic [3:0]  opcode;
  logic [1:0]  sel_1, sel_2, out_sel;
  logic [7:0]  imm_1, imm_2;

  logic        m_in_ready, m_out_valid, m_type_1, m_type_2, m_illegal;
  logic [3:0]  m_opcode;
  logic [1:0]  m_sel_1, m_sel_2, m_out_sel;
  logic [7:0]  m_imm_1, m_imm_2;

  instruction_decode_stage u_dut (
    .clk                      (clk),
    .reset                    (reset),
    .in_valid                 (in_valid),
    .in_ready                 (in_ready),
    .in_instruction           (in_instruction),
    .flush                    (flush),
    .out_valid                (out_valid),
    .out_ready                (out_ready),
    .opcode                   (opcode),
    .input_type_1             (input_type_1),
    .input_type_2             (input_type_2),
    .input_register_selector_1(sel_1),
    .input_register_selector_2(sel_2),
    .input_immediate_1        (imm_1),
    .input_immediate_2        (imm_2),
    .output_register_selector (out_sel),
    .illegal                  (illegal)
  );

  instruction_decode_stage #(
    .LEGAL_OPCODE_MASK(16'hFFF7)
  ) u_dut_mask (
    .clk                      (clk),
    .reset                    (reset),
    .in_valid                 (in_valid),
    .in_ready                 (m_in_ready),
    .in_instruction           (in_instruction),
    .flush                    (flush),
    .out_valid                (m_out_valid),
    .out_ready                (out_ready),
    .opcode                   (m_opcode),
    .input_type_1             (m_type_1),
    .input_type_2             (m_type_2),
    .input_register_selector_1(m_sel_1),
    .input_register_selector_2(m_sel_2),
    .input_immediate_1        (m_imm_1),
    .input_immediate_2        (m_imm_2),
    .output_register_selector (m_out_sel),
    .illegal                  (m_illegal)
  );

  always #5 clk = ~clk;

  logic [28:0] dut_vec;
  assign dut_vec = {opcode, input_type_1, sel_1, imm_1, input_type_2, sel_2, imm_2, out_sel,
                    illegal};

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_acc    = 0;
  logic [31:0] model_q[$];

  localparam logic [28:0] Pin00 = {4'd3, 1'b1, 2'd3, 8'hC5, 1'b0, 2'd0, 8'h2A, 2'd2, 1'b0};
  localparam logic [28:0] Pin01 = {4'd3, 1'b1, 2'd3, 8'hC5, 1'b0, 2'd0, 8'h2A, 2'd2, 1'b1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode from the field layout, using plain shifts and masks on the word.
  function automatic logic [28:0] expect_dec(input logic [31:0] w, input logic [15:0] mask);
    logic [3:0] opc;
    logic [7:0] op1, op2;
    logic       t1, t2, ill;
    logic [1:0] os;
    opc = 4'((w >> 28) & 32'hF);
    t1  = 1'((w >> 27) & 32'h1);
    op1 = 8'((w >> 19) & 32'hFF);
    t2  = 1'((w >> 18) & 32'h1);
    op2 = 8'((w >> 10) & 32'hFF);
    os  = 2'((w >> 8) & 32'h3);
    ill = ((w & 32'hFF) != 0) || (mask[opc] == 1'b0);
    return {opc, t1, 2'(op1 >> 6), op1, t2, 2'(op2 >> 6), op2, os, ill};
  endfunction

  // Compare on the falling edge, then advance the queue model for the coming rising edge.
  always @(negedge clk) begin
    if (reset) begin
      model_q.delete();
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_in_ready", in_ready, 1'b1);
      check("reset_fields", dut_vec, 29'd0);
    end else begin
      bit exp_valid, exp_ready;
      exp_valid = model_q.size() != 0;
      exp_ready = model_q.size() < 2;
      check("out_valid", out_valid, exp_valid);
      check("in_ready", in_ready, exp_ready);
      if (exp_valid) check("decode", dut_vec, expect_dec(model_q[0], 16'hFFFF));
      if (flush) begin
        model_q.delete();
      end else begin
        if (exp_valid && out_ready) void'(model_q.pop_front());
        if (in_valid && exp_ready) begin
          model_q.push_back(in_instruction);
          n_acc++;
        end
      end
    end
  end

  // Apply inputs for the next rising edge; in_ready must not move when they change.
  task automatic drive(input logic v, input logic [31:0] w, input logic ordy, input logic fl);
    logic ir_before;
    @(posedge clk);
    #2;
    ir_before      = in_ready;
    in_valid       = v;
    in_instruction = w;
    out_ready      = ordy;
    flush          = fl;
    #1 check("in_ready_comb", in_ready, ir_before);
  endtask

  initial begin
    int          start, cyc;
    logic [31:0] w;
    in_valid = 0; flush = 0; out_ready = 0; in_instruction = '0; reset = 0;
    #1 reset = 1;
    check("model_pin_legal", expect_dec(32'h3E28AA00, 16'hFFFF), Pin00);
    check("model_pin_resv", expect_dec(32'h3E28AA01, 16'hFFFF), Pin01);
    check("model_pin_mask", expect_dec(32'h3E28AA00, 16'hFFF7), Pin01);
    #2;
    check("por_out_valid", out_valid, 1'b0);
    check("por_in_ready", in_ready, 1'b1);
    repeat (3) @(posedge clk);
    #2 reset = 0;

    // Basic decode, one cycle after acceptance.
    drive(1, 32'h3E28AA00, 1, 0);
    drive(0, 0, 1, 0);
    check("d_basic_vec", dut_vec, Pin00);
    check("d_basic_valid", out_valid, 1'b1);
    check("d_mask_illegal", m_illegal, 1'b1);
    drive(1, 32'h3E28AA01, 1, 0);
    drive(0, 0, 1, 0);
    check("d_resv_vec", dut_vec, Pin01);

    // Back-pressure: A held, B skidded, C waits; then all three drain in order.
    drive(1, 32'h1000_0000, 0, 0);
    drive(1, 32'h2000_0000, 0, 0);
    drive(1, 32'h3000_0000, 0, 0);
    check("bp_in_ready_low", in_ready, 1'b0);
    check("bp_hold_a", opcode, 4'd1);
    drive(1, 32'h3000_0000, 1, 0);
    check("bp_still_a", opcode, 4'd1);
    drive(1, 32'h3000_0000, 1, 0);
    check("bp_b_out", opcode, 4'd2);
    check("bp_in_ready_up", in_ready, 1'b1);
    drive(0, 0, 0, 0);
    check("bp_c_out", opcode, 4'd3);

    // Flush with both entries full and a word offered.
    drive(1, 32'h4000_0000, 0, 0);
    drive(1, 32'h5000_0000, 0, 1);
    check("fl_full", in_ready, 1'b0);
    drive(0, 0, 1, 0);
    check("fl_out_valid", out_valid, 1'b0);
    check("fl_in_ready", in_ready, 1'b1);
    // Flush discards a word accepted in the same cycle.
    drive(1, 32'h6000_0000, 1, 1);
    drive(0, 0, 1, 0);
    check("fl_same_cycle", out_valid, 1'b0);

    // Asynchronous reset while holding a word.
    drive(1, 32'h7000_0000, 0, 0);
    drive(0, 0, 0, 0);
    check("rst_pre_valid", out_valid, 1'b1);
    reset = 1;
    #1;
    check("rst_async_valid", out_valid, 1'b0);
    check("rst_async_fields", dut_vec, 29'd0);
    check("rst_async_ready", in_ready, 1'b1);
    @(posedge clk);
    #2 reset = 0;
    drive(1, 32'h3E28AA00, 1, 0);
    drive(0, 0, 1, 0);
    check("rst_after_vec", dut_vec, Pin00);

    // Random traffic against the queue model.
    start = n_acc;
    cyc   = 0;
    while (n_acc - start < 1000 && cyc < 30000) begin
      w = $urandom;
      if ($urandom_range(0, 3) != 0) w[7:0] = 8'h00;
      drive($urandom_range(0, 9) < 7, w, $urandom_range(0, 9) < 6, $urandom_range(0, 99) == 0);
      cyc++;
    end
    check("rand_words_done", (n_acc - start) >= 1000, 1'b1);
    repeat (4) drive(0, 0, 1, 0);
    check("rand_drained", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_decode_stage.md
INSTRUCTION_DECODE_STAGE -- requirements
Module: instruction_decode_stage

Interface
REQ-001 Parameter INSTR_WIDTH, default 32: instruction word width.
REQ-002 Parameter OPCODE_WIDTH, default 4: opcode field width.
REQ-003 Parameter IMM_WIDTH, default 8: operand field width (immediate form).
REQ-004 Parameter REG_SEL_WIDTH, default 2: register selector width; must not exceed IMM_WIDTH.
REQ-005 Parameter LEGAL_OPCODE_MASK, default all ones (2**OPCODE_WIDTH bits): bit n set means opcode n is legal.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 in_valid  input  1  upstream instruction present.
REQ-009 in_ready  output  1  stage can accept an instruction this cycle.
REQ-010 in_instruction  input  INSTR_WIDTH  raw instruction word.
REQ-011 flush  input  1  synchronous discard of all held instructions.
REQ-012 out_valid  output  1  decoded instruction present.
REQ-013 out_ready  input  1  downstream accepts the decoded instruction.
REQ-014 opcode  output  OPCODE_WIDTH; input_type_1, input_type_2  output  1 each.
REQ-015 input_register_selector_1/_2  output  REG_SEL_WIDTH; input_immediate_1/_2  output  IMM_WIDTH.
REQ-016 output_register_selector  output  REG_SEL_WIDTH; illegal  output  1  decoded word is invalid.

Function
REQ-017 Field layout, MSB down: opcode, type_1, operand_1 (IMM_WIDTH), type_2, operand_2 (IMM_WIDTH), output selector (REG_SEL_WIDTH), remaining low bits reserved.
REQ-018 Each register selector SHALL be the top REG_SEL_WIDTH bits of its operand field; each immediate SHALL be the full operand field, both always driven regardless of type bit.
REQ-019 input_type_2 SHALL come from the type_2 bit, never from type_1.
REQ-020 illegal SHALL be 1 when LEGAL_OPCODE_MASK[opcode] is 0 or any reserved bit is 1.
REQ-021 Transfer occurs on in_valid && in_ready (input) and out_valid && out_ready (output).
REQ-022 Storage SHALL be a two-entry skid buffer: output register plus one skid register.
REQ-023 in_ready SHALL equal NOT skid_valid, driven from a register only, with no combinational path from out_ready.
REQ-024 An accepted instruction SHALL appear decoded on the outputs one cycle after acceptance when the output register is empty or draining.
REQ-025 Output full, out_ready=0, input accepted: word goes to skid and in_ready drops next cycle.
REQ-026 Skid full and output drained: skid moves to the output register the next cycle and in_ready rises.
REQ-027 Decoded outputs SHALL stay stable while out_valid=1 and out_ready=0.
REQ-028 Order SHALL be preserved; no instruction dropped or duplicated except by flush or reset.
REQ-029 flush=1 SHALL clear both valid flags at the next edge and discard any word accepted in the same cycle; flush has priority over every transfer.
REQ-030 Simultaneous output transfer and input acceptance with an empty skid: new word goes straight to the output register.

Reset
REQ-031 reset SHALL immediately clear out_valid and skid_valid and zero all decoded outputs, including illegal.
REQ-032 in_ready SHALL read 1 during and after reset.
REQ-033 Reset mid-transfer SHALL discard all held words; the first accept after release decodes normally.

Structure
REQ-034 A shared package SHALL hold default field-width constants, a field-position helper, and the decoded-instruction packed type used by both entries.
REQ-035 Field extraction and the illegal check SHALL sit in one combinational sub-module, instruction_field_extract, instantiated once at the input.
REQ-036 An elaboration-time check SHALL fail when OPCODE_WIDTH+2*(1+IMM_WIDTH)+REG_SEL_WIDTH exceeds INSTR_WIDTH.

Verification
REQ-037 Defaults, 0x3E28AA00 accepted, out_ready=1 -> next cycle: opcode 3, type_1 1, sel_1 3, imm_1 0xC5, type_2 0, sel_2 0, imm_2 0x2A, out sel 2, illegal 0.
REQ-038 0x3E28AA01 -> same fields with illegal 1; LEGAL_OPCODE_MASK=16'hFFF7 with 0x3E28AA00 -> illegal 1.
REQ-039 out_ready=0, three back-to-back words A,B,C -> A held, B skidded, in_ready 0, C not accepted; out_ready=1 -> A,B,C leave in order, one per cycle.
REQ-040 Both entries full, flush=1 with in_valid=1 -> next cycle out_valid 0, in_ready 1, nothing emitted.
REQ-041 Reset asserted between clock edges while holding A -> outputs zero at once, out_valid 0; first word after release emitted correctly.
REQ-042 Random in_valid/out_ready, 1000 words -> output sequence equals input sequence; in_ready never depends combinationally on out_ready.
